gb_cart_bus_master: RTL
=======================

Name: gb_cart_bus_master

Overview:
- Initiator end of the Game Boy cartridge bus: generates the free-running PHI clock and performs A/D/nRD/nWR/nCS read and write cycles on behalf of an on-chip requester.
- Drives a physical cartridge, or loops back into our cartridge-side register/RAM/ROM logic, for self-test and host-driven register and SRAM access.
- Sits beside the cartridge responder logic; the tristate pad muxing lives in the top level, so this block exposes split data-in, data-out and output-enable signals.

Parameters:
PHASE_DIV, 24, sys_clock cycles per bus phase; 4 phases per PHI period; minimum 2.
WR_HOLD, 2, sys_clock cycles cart_d_oe stays high after nWR rises; minimum 1, must be < PHASE_DIV.

Ports:
sys_clock  in  1  block clock
resetn  in  1  asynchronous, active-low reset
req_valid  in  1  request offered
req_ready  out  1  request holding slot free
req_write  in  1  1 = write, 0 = read
req_addr  in  16  bus address
req_wdata  in  8  write data
req_cs  in  1  assert nCS for this cycle (used only without the macro)
rsp_valid  out  1  one-cycle pulse, bus cycle complete
rsp_write  out  1  completed cycle was a write
rsp_rdata  out  8  sampled read data; 0 for writes
busy  out  1  bus cycle active or request pending
cart_clk  out  1  PHI
cart_a  out  16  address
cart_d_out  out  8  data driven on writes
cart_d_oe  out  1  data output enable
cart_d_in  in  8  data bus input
cart_nrd  out  1  read strobe, active low
cart_nwr  out  1  write strobe, active low
cart_ncs  out  1  SRAM-region chip select, active low

Behaviour:
- Reset values: req_ready=1, rsp_valid=0, rsp_write=0, rsp_rdata=0, busy=0, cart_clk=1, cart_a=16'h0000, cart_d_out=0, cart_d_oe=0, cart_nrd=1, cart_nwr=1, cart_ncs=1.
- Reset is asynchronous: asserted mid-cycle, all outputs return to reset values immediately; pending and active requests are dropped; no rsp_valid is issued.
- Phase generator: counter runs 0..PHASE_DIV-1; phase 0..3 advances on each counter wrap; runs continuously.
  - cart_clk=1 in phases 0-1, 0 in phases 2-3.
  - Boundary = last sys_clock of phase 3.
- Holding slot (1 entry):
  - req_ready = !pending, registered.
  - Handshake is req_valid && req_ready; the slot captures write, addr, wdata and cs.
  - At each boundary, a pending slot moves to the active cycle and the slot frees. req_ready rises the following clock.
- FSM states:
  - IDLE -> ACTIVE at a boundary with pending=1.
  - ACTIVE -> ACTIVE at a boundary with pending=1 (back-to-back, zero idle phases).
  - ACTIVE -> IDLE at a boundary otherwise.
- Read cycle:
  - Phase 0: cart_a driven, cart_nrd=0.
  - Phases 1-3: cart_ncs=cs_eff.
  - cart_d_in sampled on the boundary clock.
  - The next clock: rsp_valid=1, rsp_rdata=sample, cart_nrd=1 and cart_ncs=1 unless the next cycle asserts them.
- Write cycle:
  - Phase 0: cart_a driven, cart_nrd=1.
  - Phase 1 onward: cart_d_out=wdata, cart_d_oe=1, cart_ncs=cs_eff.
  - Phases 2-3: cart_nwr=0.
  - At the boundary: cart_nwr=1, cart_ncs=1 and rsp_valid with rsp_write=1.
  - cart_d_oe falls WR_HOLD clocks after nwr rises, even when a read follows; a following read's nRD may overlap, because the responder drives only after nCS or address decode in phase 1.
- IDLE: cart_a holds the last address, all strobes are high, cart_d_oe=0.
- busy = pending || state==ACTIVE.
- req_valid while req_ready=0 is ignored (no overwrite).

Optional Feature:
- GB_CART_BUS_MASTER_CS_AUTO_EN defined: cs_eff decoded from address, true for 16'hA000..16'hFDFF inclusive; req_cs is ignored.
- Not defined: cs_eff = captured req_cs.

Decomposition:
- Package gb_bus_pkg:
  - phase enum (PH0..PH3) and FSM state enum;
  - constants GB_CS_BASE=16'hA000, GB_CS_END=16'hFDFF;
  - idle/reset strobe levels.
- Sub-module gb_phase_gen (parameter PHASE_DIV) outputs phase[1:0], cart_clk and the boundary strobe.

Test Plan:
1. PHASE_DIV=4, release reset, no requests -> cart_clk period 16 clocks, strobes high, req_ready=1, busy=0, rsp_valid never asserts.
2. Read A000 with cart_d_in=8'h5A, macro on:
   - nRD low for 16 clocks, nCS low for 12 (phases 1-3);
   - rsp_valid one clock with rsp_rdata=8'h5A, rsp_write=0.
3. Write 4000 data 8'h10, macro on:
   - nCS stays high, nWR low for 8 clocks;
   - d_oe high from phase 1 until 2 clocks after nWR rises, cart_d_out=8'h10;
   - rsp_write=1.
4. Two writes issued back-to-back (A000=8'h01, A001=8'h02) -> second cycle's phase 0 follows the first boundary with no idle phase; req_ready deasserts after each accept; two rsp_valid pulses 16 clocks apart.
5. resetn low in phase 2 of a write -> nWR, nCS and d_oe return to 1/1/0 asynchronously; no rsp_valid; after release, req_ready=1 and busy=0.
6. Macro off: read 4000 with req_cs=1 -> nCS asserted; read A000 with req_cs=0 -> nCS stays high.

Source files
------------

// File: rtl/gb_bus_pkg.sv
// rtl/gb_bus_pkg.sv - shared types and constants for the Game Boy cartridge bus master
package gb_bus_pkg;

    typedef enum logic [1:0] {
        PH0 = 2'd0,
        PH1 = 2'd1,
        PH2 = 2'd2,
        PH3 = 2'd3
    } ph_e;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } st_e;

    localparam logic [15:0] GB_CS_BASE  = 16'hA000;
    localparam logic [15:0] GB_CS_END   = 16'hFDFF;
    localparam logic        STROBE_IDLE = 1'b1;
    localparam logic        PHI_RESET   = 1'b1;

    function automatic logic cs_decode(input logic [15:0] addr);
        return (addr >= GB_CS_BASE) && (addr <= GB_CS_END);
    endfunction

endpackage

// File: rtl/gb_phase_gen.sv
// rtl/gb_phase_gen.sv - free-running four-phase PHI generator with phase-end and cycle-boundary strobes
module gb_phase_gen
    import gb_bus_pkg::*;
#(
    parameter int PHASE_DIV = 24
) (
    input  logic sys_clock,
    input  logic resetn,
    output ph_e  phase,
    output logic phase_end,
    output logic boundary,
    output logic cart_clk
);

    localparam int CW = (PHASE_DIV > 2) ? $clog2(PHASE_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(PHASE_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    ph_e           phase_q, phase_d;
    logic          clk_q, clk_d;

    always_comb begin
        phase_end = (cnt_q == CNT_LAST);
        boundary  = phase_end && (phase_q == PH3);
        cnt_d     = phase_end ? '0 : cnt_q + CW'(1);
        phase_d   = phase_end ? ph_e'(phase_q + 2'd1) : phase_q;
        clk_d     = (phase_d == PH0) || (phase_d == PH1);
    end

    always_ff @(posedge sys_clock or negedge resetn) begin
        if (!resetn) begin
            cnt_q   <= '0;
            phase_q <= PH0;
            clk_q   <= PHI_RESET;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
            clk_q   <= clk_d;
        end
    end

    assign phase    = phase_q;
    assign cart_clk = clk_q;

endmodule

// File: rtl/gb_cart_bus_master.sv
// rtl/gb_cart_bus_master.sv - cartridge bus initiator; GB_CART_BUS_MASTER_CS_AUTO_EN selects address-decoded nCS
module gb_cart_bus_master
    import gb_bus_pkg::*;
#(
    parameter int PHASE_DIV = 24,
    parameter int WR_HOLD   = 2
) (
    input  logic        sys_clock,
    input  logic        resetn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [15:0] req_addr,
    input  logic [7:0]  req_wdata,
    input  logic        req_cs,
    output logic        rsp_valid,
    output logic        rsp_write,
    output logic [7:0]  rsp_rdata,
    output logic        busy,
    output logic        cart_clk,
    output logic [15:0] cart_a,
    output logic [7:0]  cart_d_out,
    output logic        cart_d_oe,
    input  logic [7:0]  cart_d_in,
    output logic        cart_nrd,
    output logic        cart_nwr,
    output logic        cart_ncs
);

    localparam int HW = $clog2(WR_HOLD + 1);

    ph_e  phase;
    logic phase_end;
    logic boundary;

    gb_phase_gen #(.PHASE_DIV(PHASE_DIV)) u_phase_gen (
        .sys_clock (sys_clock),
        .resetn    (resetn),
        .phase     (phase),
        .phase_end (phase_end),
        .boundary  (boundary),
        .cart_clk  (cart_clk)
    );

    st_e         state_q, state_d;
    logic        pending_q, pending_d;
    logic        req_ready_q, req_ready_d;
    logic        slot_write_q, slot_write_d;
    logic [15:0] slot_addr_q, slot_addr_d;
    logic [7:0]  slot_wdata_q, slot_wdata_d;
    logic        slot_cs_q, slot_cs_d;
    logic        act_write_q, act_write_d;
    logic [15:0] act_addr_q, act_addr_d;
    logic [7:0]  act_wdata_q, act_wdata_d;
    logic        act_cs_q, act_cs_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic        rsp_write_q, rsp_write_d;
    logic [7:0]  rsp_rdata_q, rsp_rdata_d;
    logic        busy_q, busy_d;
    logic [15:0] cart_a_q, cart_a_d;
    logic [7:0]  dout_q, dout_d;
    logic        oe_q, oe_d;
    logic        nrd_q, nrd_d;
    logic        nwr_q, nwr_d;
    logic        ncs_q, ncs_d;
    logic [HW-1:0] hold_q, hold_d;

    logic accept;
    logic take;
    ph_e  nph;
    logic nact;
    logic wr_drive;

    always_comb begin
        accept = req_valid && req_ready_q;
        take   = boundary && pending_q;

        pending_d = pending_q;
        if (take)   pending_d = 1'b0;
        if (accept) pending_d = 1'b1;
        req_ready_d = !pending_d;

        slot_write_d = accept ? req_write : slot_write_q;
        slot_addr_d  = accept ? req_addr  : slot_addr_q;
        slot_wdata_d = accept ? req_wdata : slot_wdata_q;
`ifdef GB_CART_BUS_MASTER_CS_AUTO_EN
        slot_cs_d    = accept ? cs_decode(req_addr) : slot_cs_q;
`else
        slot_cs_d    = accept ? req_cs : slot_cs_q;
`endif

        state_d     = boundary ? (pending_q ? ST_ACTIVE : ST_IDLE) : state_q;
        act_write_d = take ? slot_write_q : act_write_q;
        act_addr_d  = take ? slot_addr_q  : act_addr_q;
        act_wdata_d = take ? slot_wdata_q : act_wdata_q;
        act_cs_d    = take ? slot_cs_q    : act_cs_q;

        // Bus pins are registered from next-state values so they line up with the phase they belong to.
        nph      = phase_end ? ph_e'(phase + 2'd1) : phase;
        nact     = (state_d == ST_ACTIVE);
        wr_drive = nact && act_write_d && (nph != PH0);

        cart_a_d = nact ? act_addr_d : cart_a_q;
        nrd_d    = (nact && !act_write_d) ? 1'b0 : STROBE_IDLE;
        ncs_d    = (nact && act_cs_d && (nph != PH0)) ? 1'b0 : STROBE_IDLE;
        nwr_d    = (nact && act_write_d && ((nph == PH2) || (nph == PH3))) ? 1'b0 : STROBE_IDLE;
        dout_d   = wr_drive ? act_wdata_d : dout_q;

        // Keep driving data for WR_HOLD clocks past the nWR rising edge.
        if (!nwr_q && nwr_d)
            hold_d = HW'(WR_HOLD);
        else if (hold_q != '0)
            hold_d = hold_q - HW'(1);
        else
            hold_d = hold_q;
        oe_d = wr_drive || (hold_d != '0);

        rsp_valid_d = boundary && (state_q == ST_ACTIVE);
        rsp_write_d = rsp_valid_d ? act_write_q : rsp_write_q;
        rsp_rdata_d = rsp_valid_d ? (act_write_q ? 8'h00 : cart_d_in) : rsp_rdata_q;

        busy_d = pending_d || nact;
    end

    always_ff @(posedge sys_clock or negedge resetn) begin
        if (!resetn) begin
            state_q      <= ST_IDLE;
            pending_q    <= 1'b0;
            req_ready_q  <= 1'b1;
            slot_write_q <= 1'b0;
            slot_addr_q  <= '0;
            slot_wdata_q <= '0;
            slot_cs_q    <= 1'b0;
            act_write_q  <= 1'b0;
            act_addr_q   <= '0;
            act_wdata_q  <= '0;
            act_cs_q     <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_write_q  <= 1'b0;
            rsp_rdata_q  <= '0;
            busy_q       <= 1'b0;
            cart_a_q     <= '0;
            dout_q       <= '0;
            oe_q         <= 1'b0;
            nrd_q        <= STROBE_IDLE;
            nwr_q        <= STROBE_IDLE;
            ncs_q        <= STROBE_IDLE;
            hold_q       <= '0;
        end else begin
            state_q      <= state_d;
            pending_q    <= pending_d;
            req_ready_q  <= req_ready_d;
            slot_write_q <= slot_write_d;
            slot_addr_q  <= slot_addr_d;
            slot_wdata_q <= slot_wdata_d;
            slot_cs_q    <= slot_cs_d;
            act_write_q  <= act_write_d;
            act_addr_q   <= act_addr_d;
            act_wdata_q  <= act_wdata_d;
            act_cs_q     <= act_cs_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_write_q  <= rsp_write_d;
            rsp_rdata_q  <= rsp_rdata_d;
            busy_q       <= busy_d;
            cart_a_q     <= cart_a_d;
            dout_q       <= dout_d;
            oe_q         <= oe_d;
            nrd_q        <= nrd_d;
            nwr_q        <= nwr_d;
            ncs_q        <= ncs_d;
            hold_q       <= hold_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_write  = rsp_write_q;
    assign rsp_rdata  = rsp_rdata_q;
    assign busy       = busy_q;
    assign cart_a     = cart_a_q;
    assign cart_d_out = dout_q;
    assign cart_d_oe  = oe_q;
    assign cart_nrd   = nrd_q;
    assign cart_nwr   = nwr_q;
    assign cart_ncs   = ncs_q;

endmodule
